mem_bus_ctrl: RTL

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// Wait-state memory controller on a shared tri-state CPU data bus.
// One access per held request; illegal or conflicting requests park in ERR.
module mem_bus_ctrl #(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [31:0] BUS,
    input  logic        Memread,
    input  logic        Memwrite,
    input  logic [31:0] Addr,
    output logic        Ready,
    output logic        Err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_HOLD,
        ST_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                wr_q, wr_d;

    logic [31:0]         mem [0:(2**ADDR_W)-1];
    logic                mem_we;
    logic [ADDR_W-1:0]   acc_idx;
    logic                acc;
    logic                acc_wr;

    logic                one_req;
    logic                both_req;
    logic                any_req;
    logic                legal;
    logic [ADDR_W-1:0]   addr_idx;
    logic                drive;

    assign addr_idx = Addr[ADDR_W+1:2];
    assign legal    = (Addr[1:0] == 2'b00) &&
                      ((Addr >> (ADDR_W + 2)) == 32'd0);
    assign one_req  = Memread ^ Memwrite;
    assign both_req = Memread & Memwrite;
    assign any_req  = Memread | Memwrite;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        acc     = 1'b0;
        acc_wr  = 1'b0;
        acc_idx = idx_q;
        mem_we  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (both_req || (one_req && !legal)) begin
                    state_d = ST_ERR;
                end else if (one_req) begin
                    idx_d = addr_idx;
                    wr_d  = Memwrite;
                    if (WAIT == 0) begin
                        acc     = 1'b1;
                        acc_wr  = Memwrite;
                        acc_idx = addr_idx;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = 4'(WAIT - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Dropping the request mid-wait abandons the access silently.
                if (!any_req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    acc     = 1'b1;
                    acc_wr  = wr_q;
                    acc_idx = idx_q;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!any_req) state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (!any_req) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (acc) begin
            if (acc_wr) mem_we = 1'b1;
            else        rdata_d = mem[acc_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
        end
    end

    // Array has no reset; rst only suppresses a commit on the same edge.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[acc_idx] <= BUS;
    end

    assign Ready = (state_q == ST_DONE);
    assign Err   = (state_q == ST_ERR);

    assign drive = Memread && !Memwrite &&
                   ((state_q == ST_DONE) || (state_q == ST_HOLD));
    assign BUS   = drive ? rdata_q : 32'bz;

endmodule
